// File: rtl/gray_monitor.sv
// Purpose: decodes the upstream Gray count, checks that each step is a hold or +1, counts wraps and cross-checks sig_in.
// Latency: 2 cycles from gray_in to outputs; 4 cycles when GRAY_MON_SYNC_EN adds the two-flop synchroniser.
// Backpressure: none; one input sample is accepted every cycle.
module gray_monitor #(
    parameter int CBITS = 11,
    parameter int WBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CBITS-1:0] gray_in,
    input  logic             sig_in,
    output logic [CBITS-1:0] bin_cnt,
    output logic             valid,
    output logic             wrap_pulse,
    output logic [WBITS-1:0] wrap_cnt,
    output logic             step_err,
    output logic             sig_err
);

    typedef enum logic {INIT, TRACK} state_t;

    localparam logic [CBITS-1:0] C_ONE = {{(CBITS-1){1'b0}}, 1'b1};
    localparam logic [WBITS-1:0] W_ONE = {{(WBITS-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CBITS-1:0] s_gray;
    logic             s_sig;
    logic [CBITS-1:0] src_gray;
    logic             src_sig;
    logic [CBITS-1:0] prev_q, prev_d;
    logic [CBITS-1:0] bin_d;
    logic [CBITS-1:0] b;
    logic [CBITS-1:0] prev_inc;
    logic             wrap_pulse_d;
    logic [WBITS-1:0] wrap_cnt_d;
    logic             step_err_d;
    logic             sig_err_d;
    logic             is_hold;
    logic             is_inc;
    logic             is_wrap;

`ifdef GRAY_MON_SYNC_EN
    // Gray code changes one bit per step, so a plain two-flop synchroniser is safe for a foreign-domain counter.
    logic [CBITS-1:0] sync1_gray, sync2_gray;
    logic             sync1_sig, sync2_sig;

    // Two-flop synchroniser ahead of the sample register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_gray <= '0;
            sync2_gray <= '0;
            sync1_sig  <= 1'b0;
            sync2_sig  <= 1'b0;
        end else begin
            sync1_gray <= gray_in;
            sync2_gray <= sync1_gray;
            sync1_sig  <= sig_in;
            sync2_sig  <= sync1_sig;
        end
    end

    assign src_gray = sync2_gray;
    assign src_sig  = sync2_sig;
`else
    assign src_gray = gray_in;
    assign src_sig  = sig_in;
`endif

    // Sample register: every check works on this registered copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_gray <= '0;
            s_sig  <= 1'b0;
        end else begin
            s_gray <= src_gray;
            s_sig  <= src_sig;
        end
    end

    // Gray to binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        b = '0;
        for (int i = 0; i < CBITS; i++) begin
            b[i] = ^(s_gray >> i);
        end
    end

    assign prev_inc = prev_q + C_ONE;
    assign is_hold  = (b == prev_q);
    assign is_inc   = (b == prev_inc);
    assign is_wrap  = is_inc && (&prev_q);

    // Next-state and status update; an illegal step resynchronises but never counts as a wrap.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        bin_d        = bin_cnt;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt;
        step_err_d   = step_err;
        sig_err_d    = sig_err;
        case (state_q)
            INIT: begin
                prev_d  = b;
                bin_d   = b;
                state_d = TRACK;
            end
            TRACK: begin
                if (is_inc) begin
                    prev_d = b;
                    bin_d  = b;
                end else if (!is_hold) begin
                    step_err_d = 1'b1;
                    prev_d     = b;
                    bin_d      = b;
                end
                if (is_wrap) begin
                    wrap_pulse_d = 1'b1;
                    if (!(&wrap_cnt)) begin
                        wrap_cnt_d = wrap_cnt + W_ONE;
                    end
                end
                if ((s_sig && (b != '0)) || (is_wrap && !s_sig)) begin
                    sig_err_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            prev_q     <= '0;
            bin_cnt    <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            sig_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            bin_cnt    <= bin_d;
            wrap_pulse <= wrap_pulse_d;
            wrap_cnt   <= wrap_cnt_d;
            step_err   <= step_err_d;
            sig_err    <= sig_err_d;
        end
    end

    assign valid = (state_q == TRACK);

endmodule

// File: tb/tb_gray_monitor.sv
// Purpose: directed bench for gray_monitor covering counting, holds, wraps, illegal steps, sig checks and saturation.
// Latency: expects outputs LAT cycles after each driven sample.
// Backpressure: none; a new sample is driven each cycle.
module tb_gray_monitor;

    localparam int CBITS = 11;
    localparam int WBITS = 8;
`ifdef GRAY_MON_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CBITS-1:0] gray_in = '0;
    logic             sig_in = 1'b0;
    logic [CBITS-1:0] bin_cnt;
    logic             valid;
    logic             wrap_pulse;
    logic [WBITS-1:0] wrap_cnt;
    logic             step_err;
    logic             sig_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_seen = 0;
    int excl_viol  = 0;
    logic step_err_prev = 1'b0;

    gray_monitor #(.CBITS(CBITS), .WBITS(WBITS)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .sig_in(sig_in),
        .bin_cnt(bin_cnt), .valid(valid), .wrap_pulse(wrap_pulse),
        .wrap_cnt(wrap_cnt), .step_err(step_err), .sig_err(sig_err)
    );

    always #5 clk = ~clk;

    // Watch every cycle for wrap pulses and for a wrap coinciding with a new step error.
    always @(negedge clk) begin
        if (wrap_pulse) pulse_seen = pulse_seen + 1;
        if (wrap_pulse && step_err && !step_err_prev) excl_viol = excl_viol + 1;
        step_err_prev = step_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    function automatic logic [CBITS-1:0] to_gray(input int n);
        logic [CBITS-1:0] v;
        v = CBITS'(n);
        return v ^ (v >> 1);
    endfunction

    task automatic drive(input int n, input logic s);
        @(negedge clk);
        gray_in = to_gray(n);
        sig_in  = s;
    endtask

    task automatic settle();
        repeat (LAT) @(negedge clk);
    endtask

    // Walk consecutive counts from..to with sig_in low.
    task automatic walk(input int from, input int to);
        for (int n = from; n <= to; n++) drive(n, 1'b0);
    endtask

    // Reset with input at Gray 0, then release and let INIT take its reference.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        gray_in = '0;
        sig_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle();
        pulse_seen = 0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bin_cnt !== '0) begin n_fail++; $display("FAIL reset_bin_cnt got %0d want 0", bin_cnt); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_checks++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_pulse got %b want 0", wrap_pulse); end
        n_checks++; if (wrap_cnt !== '0) begin n_fail++; $display("FAIL reset_wrap_cnt got %0d want 0", wrap_cnt); end
        n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL reset_step_err got %b want 0", step_err); end
        n_checks++; if (sig_err !== 1'b0) begin n_fail++; $display("FAIL reset_sig_err got %b want 0", sig_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL valid_after_first_sample got %b want 1", valid); end
    endtask

    task automatic test_count();
        // Drive 0,1,3,2,6 back to back; each shows up on bin_cnt LAT negedges later.
        for (int j = 0; j < 5 + LAT; j++) begin
            @(negedge clk);
            if (j >= LAT) begin
                n_checks++;
                if (bin_cnt !== CBITS'(j - LAT)) begin
                    n_fail++; $display("FAIL count_bin_cnt step %0d got %0d want %0d", j - LAT, bin_cnt, j - LAT);
                end
            end
            if (j < 5) begin gray_in = to_gray(j); sig_in = 1'b0; end
        end
        n_checks++; if ({step_err, sig_err, wrap_pulse} !== 3'b000) begin n_fail++; $display("FAIL count_flags got %b want 000", {step_err, sig_err, wrap_pulse}); end
    endtask

    task automatic test_hold_and_wrap();
        do_reset();
        walk(1, 2);
        for (int k = 0; k < 5 + LAT; k++) begin
            drive(2, 1'b0);
            if (k >= LAT) begin
                n_checks++; if (bin_cnt !== 11'd2) begin n_fail++; $display("FAIL hold_bin_cnt got %0d want 2", bin_cnt); end
            end
        end
        n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL hold_step_err got %b want 0", step_err); end
        walk(3, 2047);
        settle();
        n_checks++; if (bin_cnt !== 11'd2047) begin n_fail++; $display("FAIL pre_wrap_bin_cnt got %0d want 2047", bin_cnt); end
        n_checks++; if (wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL pre_wrap_wrap_cnt got %0d want 0", wrap_cnt); end
        drive(0, 1'b1);
        drive(0, 1'b0);
        settle();
        n_checks++; if (pulse_seen !== 1) begin n_fail++; $display("FAIL wrap_pulse_cycles got %0d want 1", pulse_seen); end
        n_checks++; if (wrap_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_cnt got %0d want 1", wrap_cnt); end
        n_checks++; if (bin_cnt !== 11'd0) begin n_fail++; $display("FAIL wrap_bin_cnt got %0d want 0", bin_cnt); end
        n_checks++; if (sig_err !== 1'b0) begin n_fail++; $display("FAIL wrap_sig_err got %b want 0", sig_err); end
        n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL wrap_step_err got %b want 0", step_err); end
    endtask

    task automatic test_illegal_step();
        do_reset();
        walk(1, 5);
        drive(9, 1'b0);
        settle();
        n_checks++; if (step_err !== 1'b1) begin n_fail++; $display("FAIL illegal_step_err got %b want 1", step_err); end
        n_checks++; if (bin_cnt !== 11'd9) begin n_fail++; $display("FAIL illegal_bin_cnt got %0d want 9", bin_cnt); end
        n_checks++; if (wrap_pulse !== 1'b0 || pulse_seen !== 0) begin n_fail++; $display("FAIL illegal_no_wrap got %0d want 0", pulse_seen); end
        drive(10, 1'b0);
        settle();
        n_checks++; if (bin_cnt !== 11'd10) begin n_fail++; $display("FAIL after_illegal_bin_cnt got %0d want 10", bin_cnt); end
        n_checks++; if (step_err !== 1'b1) begin n_fail++; $display("FAIL sticky_step_err got %b want 1", step_err); end
        n_checks++; if (sig_err !== 1'b0) begin n_fail++; $display("FAIL illegal_sig_err got %b want 0", sig_err); end
    endtask

    task automatic test_sig_mismatch();
        do_reset();
        walk(1, 3);
        drive(4, 1'b1);
        drive(4, 1'b0);
        settle();
        n_checks++; if (sig_err !== 1'b1) begin n_fail++; $display("FAIL sig_err_nonzero got %b want 1", sig_err); end
        n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL sig_step_err got %b want 0", step_err); end
        walk(5, 2047);
        drive(0, 1'b0);
        settle();
        n_checks++; if (wrap_cnt !== 8'd1) begin n_fail++; $display("FAIL sig_wrap_cnt got %0d want 1", wrap_cnt); end
        n_checks++; if (sig_err !== 1'b1) begin n_fail++; $display("FAIL sig_err_sticky got %b want 1", sig_err); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        // Resync to 2047 via an illegal step, then wrap to 0: one wrap every two cycles.
        for (int w = 0; w < 260; w++) begin
            drive(2047, 1'b0);
            drive(0, 1'b1);
        end
        drive(0, 1'b0);
        settle();
        n_checks++; if (wrap_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate_wrap_cnt got %0d want 255", wrap_cnt); end
        n_checks++; if (pulse_seen !== 260) begin n_fail++; $display("FAIL saturate_pulses got %0d want 260", pulse_seen); end
        n_checks++; if (excl_viol !== 0) begin n_fail++; $display("FAIL step_wrap_exclusive got %0d want 0", excl_viol); end
        drive(5, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bin_cnt, valid, wrap_pulse, wrap_cnt, step_err, sig_err} !== '0) begin
            n_fail++; $display("FAIL midrun_reset outputs bin=%0d valid=%b pulse=%b wcnt=%0d serr=%b gerr=%b want all 0",
                               bin_cnt, valid, wrap_pulse, wrap_cnt, step_err, sig_err);
        end
        gray_in = '0;
        sig_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_before_sample got %b want 0", valid); end
        @(negedge clk);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL valid_after_reset got %b want 1", valid); end
        n_checks++; if (wrap_cnt !== 8'd0) begin n_fail++; $display("FAIL post_reset_wrap_cnt got %0d want 0", wrap_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_count();
        test_hold_and_wrap();
        test_illegal_step();
        test_sig_mismatch();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
